llc_in_sched: RTL and testbench

Input scheduler for the LLC controller. It arbitrates among three input channels and presents a single registered message per cycle to the LLC core pipeline:
- coherence responses (`llc_rsp_in`)
- CPU coherence requests (`llc_req_in`)
- DMA requests (`llc_dma_req_in`)

Responses have priority. Coherence and DMA requests share a round-robin slot, and an anti-starvation counter protects them from a continuous response stream. Only one request (coherence or DMA) is in flight in the core at a time. A response may overtake it.

---
 rtl/llc_in_sched_pkg.sv | 40 ++++
 rtl/llc_in_rr2.sv | 41 ++++
 rtl/llc_in_sched.sv | 168 ++++++++++++++++
 tb/tb_llc_in_sched.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_in_sched_pkg.sv
// Shared LLC input-scheduler types: message widths,
// source encodings and the registered output bundle.
package llc_in_sched_pkg;

  localparam int COH_MSG_TYPE_WIDTH = 2;
  localparam int MIX_MSG_TYPE_WIDTH = 3;
  localparam int LINE_ADDR_BITS     = 26;
  localparam int BITS_PER_LINE      = 128;
  localparam int CACHE_ID_WIDTH     = 4;
  localparam int HPROT_WIDTH        = 2;
  localparam int WORD_BITS          = 2;

  localparam logic [1:0] LLC_SRC_RSP = 2'd0;
  localparam logic [1:0] LLC_SRC_REQ = 2'd1;
  localparam logic [1:0] LLC_SRC_DMA = 2'd2;

  typedef logic [COH_MSG_TYPE_WIDTH-1:0] coh_msg_t;
  typedef logic [MIX_MSG_TYPE_WIDTH-1:0] mix_msg_t;
  typedef logic [LINE_ADDR_BITS-1:0]     line_addr_t;
  typedef logic [BITS_PER_LINE-1:0]      line_t;
  typedef logic [CACHE_ID_WIDTH-1:0]     cache_id_t;
  typedef logic [HPROT_WIDTH-1:0]        hprot_t;
  typedef logic [WORD_BITS-1:0]          word_offset_t;

  typedef struct packed {
    logic [1:0]   src;
    mix_msg_t     coh_msg;
    hprot_t       hprot;
    line_addr_t   addr;
    line_t        line;
    cache_id_t    req_id;
    word_offset_t word_offset;
    word_offset_t valid_words;
  } llc_in_msg_t;

  function automatic mix_msg_t coh2mix(coh_msg_t m);
    return mix_msg_t'(m);
  endfunction

endpackage

// File: rtl/llc_in_rr2.sv
// Two-way round-robin picker; the source not granted
// last wins a tie. Reset favours req0.
module llc_in_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (update && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/llc_in_sched.sv
// LLC input scheduler: response priority, req/dma round
// robin, anti-starvation and single in-flight request.
module llc_in_sched
  import llc_in_sched_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rsp_valid,
  output logic         rsp_ready,
  input  coh_msg_t     rsp_coh_msg,
  input  line_addr_t   rsp_addr,
  input  line_t        rsp_line,
  input  cache_id_t    rsp_req_id,
  input  logic         req_valid,
  output logic         req_ready,
  input  mix_msg_t     req_coh_msg,
  input  hprot_t       req_hprot,
  input  line_addr_t   req_addr,
  input  line_t        req_line,
  input  cache_id_t    req_req_id,
  input  word_offset_t req_word_offset,
  input  word_offset_t req_valid_words,
  input  logic         dma_valid,
  output logic         dma_ready,
  input  mix_msg_t     dma_coh_msg,
  input  hprot_t       dma_hprot,
  input  line_addr_t   dma_addr,
  input  line_t        dma_line,
  input  cache_id_t    dma_req_id,
  input  word_offset_t dma_word_offset,
  input  word_offset_t dma_valid_words,
  input  logic         req_done,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_src,
  output mix_msg_t     out_coh_msg,
  output hprot_t       out_hprot,
  output line_addr_t   out_addr,
  output line_t        out_line,
  output cache_id_t    out_req_id,
  output word_offset_t out_word_offset,
  output word_offset_t out_valid_words,
  output logic         req_busy
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

  logic slot_free, busy_free;
  logic req_elig, dma_elig, cls_elig;
  logic starve, rsp_win, cls_win;
  logic [1:0] rr_gnt;
  logic rr_upd;

  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  logic ov_q, ov_d;
  llc_in_msg_t out_q, out_d;
  llc_in_msg_t rsp_msg, req_msg, dma_msg;

  assign slot_free = !ov_q || out_ready;
  assign busy_free = !busy_q || req_done;
  assign req_elig  = req_valid && busy_free;
  assign dma_elig  = dma_valid && busy_free;
  assign cls_elig  = req_elig || dma_elig;
  assign starve    = (cnt_q == CNT_MAX) && cls_elig;
  assign rsp_win   = rsp_valid && !starve;
  assign cls_win   = cls_elig && !rsp_win;

  llc_in_rr2 u_rr (
    .clk    (clk),
    .rst_n  (rst),
    .req0   (req_elig),
    .req1   (dma_elig),
    .update (rr_upd),
    .gnt    (rr_gnt)
  );

  assign rsp_ready = slot_free && rsp_win;
  assign req_ready = slot_free && cls_win && rr_gnt[0];
  assign dma_ready = slot_free && cls_win && rr_gnt[1];
  assign rr_upd    = req_ready || dma_ready;

  assign rsp_msg = '{src: LLC_SRC_RSP,
                     coh_msg: coh2mix(rsp_coh_msg),
                     hprot: '0,
                     addr: rsp_addr,
                     line: rsp_line,
                     req_id: rsp_req_id,
                     word_offset: '0,
                     valid_words: '0};

  assign req_msg = '{src: LLC_SRC_REQ,
                     coh_msg: req_coh_msg,
                     hprot: req_hprot,
                     addr: req_addr,
                     line: req_line,
                     req_id: req_req_id,
                     word_offset: req_word_offset,
                     valid_words: req_valid_words};

  assign dma_msg = '{src: LLC_SRC_DMA,
                     coh_msg: dma_coh_msg,
                     hprot: dma_hprot,
                     addr: dma_addr,
                     line: dma_line,
                     req_id: dma_req_id,
                     word_offset: dma_word_offset,
                     valid_words: dma_valid_words};

  // Count only responses that actually kept a request waiting
  always_comb begin
    cnt_d = cnt_q;
    if (rr_upd || !(req_valid || dma_valid)) begin
      cnt_d = '0;
    end else if (rsp_ready && cls_elig && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (rr_upd) begin
      busy_d = 1'b1;
    end else if (req_done) begin
      busy_d = 1'b0;
    end
  end

  always_comb begin
    out_d = out_q;
    ov_d  = ov_q && !out_ready;
    unique case (1'b1)
      rsp_ready: begin out_d = rsp_msg; ov_d = 1'b1; end
      req_ready: begin out_d = req_msg; ov_d = 1'b1; end
      dma_ready: begin out_d = dma_msg; ov_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      ov_q   <= 1'b0;
      out_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      ov_q   <= ov_d;
      out_q  <= out_d;
    end
  end

  assign out_valid       = ov_q;
  assign out_src         = out_q.src;
  assign out_coh_msg     = out_q.coh_msg;
  assign out_hprot       = out_q.hprot;
  assign out_addr        = out_q.addr;
  assign out_line        = out_q.line;
  assign out_req_id      = out_q.req_id;
  assign out_word_offset = out_q.word_offset;
  assign out_valid_words = out_q.valid_words;
  assign req_busy        = busy_q;

endmodule

// File: tb/tb_llc_in_sched.sv
// Bench for llc_in_sched: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_llc_in_sched;
  import llc_in_sched_pkg::*;

  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst;
  logic rsp_valid, rsp_ready;
  coh_msg_t rsp_coh_msg;
  line_addr_t rsp_addr;
  line_t rsp_line;
  cache_id_t rsp_req_id;
  logic req_valid, req_ready;
  mix_msg_t req_coh_msg;
  hprot_t req_hprot;
  line_addr_t req_addr;
  line_t req_line;
  cache_id_t req_req_id;
  word_offset_t req_word_offset, req_valid_words;
  logic dma_valid, dma_ready;
  mix_msg_t dma_coh_msg;
  hprot_t dma_hprot;
  line_addr_t dma_addr;
  line_t dma_line;
  cache_id_t dma_req_id;
  word_offset_t dma_word_offset, dma_valid_words;
  logic req_done;
  logic out_valid, out_ready;
  logic [1:0] out_src;
  mix_msg_t out_coh_msg;
  hprot_t out_hprot;
  line_addr_t out_addr;
  line_t out_line;
  cache_id_t out_req_id;
  word_offset_t out_word_offset, out_valid_words;
  logic req_busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  llc_in_sched #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_coh_msg(rsp_coh_msg), .rsp_addr(rsp_addr),
    .rsp_line(rsp_line), .rsp_req_id(rsp_req_id),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_coh_msg(req_coh_msg), .req_hprot(req_hprot),
    .req_addr(req_addr), .req_line(req_line),
    .req_req_id(req_req_id),
    .req_word_offset(req_word_offset),
    .req_valid_words(req_valid_words),
    .dma_valid(dma_valid), .dma_ready(dma_ready),
    .dma_coh_msg(dma_coh_msg), .dma_hprot(dma_hprot),
    .dma_addr(dma_addr), .dma_line(dma_line),
    .dma_req_id(dma_req_id),
    .dma_word_offset(dma_word_offset),
    .dma_valid_words(dma_valid_words),
    .req_done(req_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .out_coh_msg(out_coh_msg),
    .out_hprot(out_hprot), .out_addr(out_addr),
    .out_line(out_line), .out_req_id(out_req_id),
    .out_word_offset(out_word_offset),
    .out_valid_words(out_valid_words),
    .req_busy(req_busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rsp_valid = 0; rsp_coh_msg = '0; rsp_addr = '0;
    rsp_line = '0; rsp_req_id = '0;
    req_valid = 0; req_coh_msg = '0; req_hprot = '0;
    req_addr = '0; req_line = '0; req_req_id = '0;
    req_word_offset = '0; req_valid_words = '0;
    dma_valid = 0; dma_coh_msg = '0; dma_hprot = '0;
    dma_addr = '0; dma_line = '0; dma_req_id = '0;
    dma_word_offset = '0; dma_valid_words = '0;
    req_done = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    cyc();
    cyc();
    rst = 1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc();
      total++;
      if ({rsp_ready, req_ready, dma_ready, out_valid,
           req_busy} !== 5'b0 || out_src !== 2'd0 ||
          out_addr !== '0) begin
        bad++;
        $display("FAIL reset_idle c%0d: rdy=%b%b%b ov=%b busy=%b src=%0d exp all 0",
                 i, rsp_ready, req_ready, dma_ready,
                 out_valid, req_busy, out_src);
      end
    end
  endtask

  task automatic test_rsp_vs_req();
    do_reset();
    out_ready = 1;
    rsp_valid = 1; rsp_addr = 26'h12345;
    rsp_coh_msg = 2'd3; rsp_req_id = 4'h9;
    req_valid = 1; req_addr = 26'h0abcd;
    req_hprot = 2'd2; req_coh_msg = 3'd5;
    #1;
    total++;
    if ({rsp_ready, req_ready, dma_ready} !== 3'b100) begin
      bad++;
      $display("FAIL rsp_prio_rdy: got %b exp 100",
               {rsp_ready, req_ready, dma_ready});
    end
    cyc();
    rsp_valid = 0;
    total++;
    if (out_valid !== 1 || out_src !== 2'd0 ||
        out_addr !== 26'h12345 || out_coh_msg !== 3'd3 ||
        out_hprot !== 2'd0 || out_req_id !== 4'h9) begin
      bad++;
      $display("FAIL rsp_out: ov=%b src=%0d addr=%h coh=%0d hp=%0d id=%h exp 1 0 12345 3 0 9",
               out_valid, out_src, out_addr, out_coh_msg,
               out_hprot, out_req_id);
    end
    #1;
    total++;
    if (req_ready !== 1) begin
      bad++;
      $display("FAIL req_after_rsp: req_ready=%b exp 1",
               req_ready);
    end
    cyc();
    req_valid = 0;
    total++;
    if (out_src !== 2'd1 || out_addr !== 26'h0abcd ||
        out_hprot !== 2'd2 || req_busy !== 1) begin
      bad++;
      $display("FAIL req_out: src=%0d addr=%h hp=%0d busy=%b exp 1 0abcd 2 1",
               out_src, out_addr, out_hprot, req_busy);
    end
    cyc();
    total++;
    if (out_valid !== 0 || req_busy !== 1) begin
      bad++;
      $display("FAIL drain: ov=%b busy=%b exp 0 1",
               out_valid, req_busy);
    end
    req_done = 1;
    cyc();
    req_done = 0;
    total++;
    if (req_busy !== 0) begin
      bad++;
      $display("FAIL done_clear: busy=%b exp 0", req_busy);
    end
  endtask

  task automatic test_rr_busy();
    do_reset();
    out_ready = 1;
    req_valid = 1; req_addr = 26'h111;
    dma_valid = 1; dma_addr = 26'h222;
    #1;
    total++;
    if ({req_ready, dma_ready} !== 2'b10) begin
      bad++;
      $display("FAIL rr_first: req/dma rdy=%b exp 10",
               {req_ready, dma_ready});
    end
    cyc();
    req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (dma_ready !== 0 || req_busy !== 1) begin
        bad++;
        $display("FAIL busy_lock c%0d: dma_ready=%b busy=%b exp 0 1",
                 i, dma_ready, req_busy);
      end
      cyc();
    end
    req_done = 1;
    #1;
    total++;
    if (dma_ready !== 1) begin
      bad++;
      $display("FAIL done_grant: dma_ready=%b exp 1",
               dma_ready);
    end
    cyc();
    req_done = 0; dma_valid = 0;
    total++;
    if (out_src !== 2'd2 || out_addr !== 26'h222 ||
        req_busy !== 1) begin
      bad++;
      $display("FAIL dma_out: src=%0d addr=%h busy=%b exp 2 222 1",
               out_src, out_addr, req_busy);
    end
    req_done = 1;
    cyc();
    req_done = 0;
  endtask

  task automatic test_starvation();
    int got[12];
    int n_rsp;
    do_reset();
    out_ready = 1;
    req_valid = 1; req_addr = 26'h3c3c;
    rsp_valid = 1;
    for (int i = 0; i < 12; i++) begin
      rsp_addr = line_addr_t'(i + 16);
      #1;
      got[i] = req_ready ? 1 : (rsp_ready ? 0 : 3);
      cyc();
    end
    n_rsp = 0;
    for (int i = 0; i < 8; i++) begin
      if (got[i] == 0) n_rsp++;
    end
    total++;
    if (n_rsp != LIMIT) begin
      bad++;
      $display("FAIL starve_rsp_count: got %0d exp %0d",
               n_rsp, LIMIT);
    end
    total++;
    if (got[8] != 1) begin
      bad++;
      $display("FAIL starve_req_9th: src=%0d exp 1",
               got[8]);
    end
    total++;
    if (got[9] != 0 || got[10] != 0) begin
      bad++;
      $display("FAIL starve_resume: src=%0d,%0d exp 0,0",
               got[9], got[10]);
    end
    rsp_valid = 0; req_valid = 0;
    req_done = 1;
    cyc();
    req_done = 0;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1;
    rsp_valid = 1; rsp_addr = 26'h0aaaa;
    cyc();
    out_ready = 0;
    rsp_addr = 26'h0cccc;
    dma_valid = 1; dma_addr = 26'h0dddd;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (out_valid !== 1 || out_addr !== 26'h0aaaa ||
          {rsp_ready, req_ready, dma_ready} !== 3'b0) begin
        bad++;
        $display("FAIL stall c%0d: ov=%b addr=%h rdy=%b exp 1 0aaaa 000",
                 i, out_valid, out_addr,
                 {rsp_ready, req_ready, dma_ready});
      end
      cyc();
    end
    out_ready = 1;
    #1;
    total++;
    if (rsp_ready !== 1) begin
      bad++;
      $display("FAIL release_rdy: rsp_ready=%b exp 1",
               rsp_ready);
    end
    cyc();
    rsp_valid = 0;
    total++;
    if (out_valid !== 1 || out_addr !== 26'h0cccc) begin
      bad++;
      $display("FAIL release_out: ov=%b addr=%h exp 1 0cccc",
               out_valid, out_addr);
    end
    cyc();
    dma_valid = 0;
    total++;
    if (out_src !== 2'd2 || out_addr !== 26'h0dddd) begin
      bad++;
      $display("FAIL release_dma: src=%0d addr=%h exp 2 0dddd",
               out_src, out_addr);
    end
    cyc();
    total++;
    if (out_valid !== 0) begin
      bad++;
      $display("FAIL no_dup: ov=%b exp 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1;
    req_valid = 1; dma_valid = 1;
    cyc();
    req_valid = 0;
    out_ready = 0;
    cyc();
    #2;
    rst = 0;
    #1;
    total++;
    if (out_valid !== 0 || req_busy !== 0) begin
      bad++;
      $display("FAIL async_rst: ov=%b busy=%b exp 0 0",
               out_valid, req_busy);
    end
    cyc();
    rst = 1;
    out_ready = 1;
    req_valid = 1;
    #1;
    total++;
    if ({req_ready, dma_ready} !== 2'b10) begin
      bad++;
      $display("FAIL rr_after_rst: rdy=%b exp 10",
               {req_ready, dma_ready});
    end
    cyc();
    clear_inputs();
  endtask

  task automatic test_random();
    logic m_ov, m_busy;
    int m_cnt, m_last, win;
    logic e_req, e_dma, e_cls, slot, free;
    logic [2:0] e_rdy;
    llc_in_msg_t m_out;
    do_reset();
    m_ov = 0; m_busy = 0; m_cnt = 0; m_last = 1;
    m_out = '0;
    for (int c = 0; c < 600; c++) begin
      rsp_valid = ($urandom_range(0, 3) != 0);
      req_valid = ($urandom_range(0, 2) == 0);
      dma_valid = ($urandom_range(0, 2) == 0);
      req_done  = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rsp_coh_msg = coh_msg_t'($urandom);
      rsp_addr = line_addr_t'($urandom);
      rsp_line = {$urandom, $urandom, $urandom, $urandom};
      rsp_req_id = cache_id_t'($urandom);
      req_coh_msg = mix_msg_t'($urandom);
      req_hprot = hprot_t'($urandom);
      req_addr = line_addr_t'($urandom);
      req_line = {$urandom, $urandom, $urandom, $urandom};
      req_req_id = cache_id_t'($urandom);
      req_word_offset = word_offset_t'($urandom);
      req_valid_words = word_offset_t'($urandom);
      dma_coh_msg = mix_msg_t'($urandom);
      dma_hprot = hprot_t'($urandom);
      dma_addr = line_addr_t'($urandom);
      dma_line = {$urandom, $urandom, $urandom, $urandom};
      dma_req_id = cache_id_t'($urandom);
      dma_word_offset = word_offset_t'($urandom);
      dma_valid_words = word_offset_t'($urandom);
      #1;
      slot  = !m_ov || out_ready;
      free  = !m_busy || req_done;
      e_req = req_valid && free;
      e_dma = dma_valid && free;
      e_cls = e_req || e_dma;
      // win: 0 rsp, 1 req, 2 dma, 3 nobody
      if (rsp_valid && !(m_cnt == LIMIT && e_cls)) win = 0;
      else if (e_req && e_dma) win = (m_last == 1) ? 1 : 2;
      else if (e_req) win = 1;
      else if (e_dma) win = 2;
      else win = 3;
      if (!slot) win = 3;
      e_rdy = {win == 0, win == 1, win == 2};
      total++;
      if ({rsp_ready, req_ready, dma_ready} !== e_rdy) begin
        bad++;
        $display("FAIL rnd_ready c%0d: got %b exp %b",
                 c, {rsp_ready, req_ready, dma_ready}, e_rdy);
      end
      if (win == 1 || win == 2) begin
        m_cnt = 0;
      end else if (!req_valid && !dma_valid) begin
        m_cnt = 0;
      end else if (win == 0 && e_cls && m_cnt < LIMIT) begin
        m_cnt++;
      end
      if (win == 1 || win == 2) begin
        m_busy = 1;
        m_last = win - 1;
      end else if (req_done) begin
        m_busy = 0;
      end
      if (win == 0) begin
        m_ov = 1;
        m_out = '0;
        m_out.src = 2'd0;
        m_out.coh_msg = {1'b0, rsp_coh_msg};
        m_out.addr = rsp_addr;
        m_out.line = rsp_line;
        m_out.req_id = rsp_req_id;
      end else if (win == 1) begin
        m_ov = 1;
        m_out = '{2'd1, req_coh_msg, req_hprot, req_addr,
                  req_line, req_req_id, req_word_offset,
                  req_valid_words};
      end else if (win == 2) begin
        m_ov = 1;
        m_out = '{2'd2, dma_coh_msg, dma_hprot, dma_addr,
                  dma_line, dma_req_id, dma_word_offset,
                  dma_valid_words};
      end else if (out_ready) begin
        m_ov = 0;
      end
      cyc();
      total++;
      if (out_valid !== m_ov || req_busy !== m_busy ||
          {out_src, out_coh_msg, out_hprot, out_addr,
           out_line, out_req_id, out_word_offset,
           out_valid_words} !== m_out) begin
        bad++;
        $display("FAIL rnd_out c%0d: ov=%b busy=%b src=%0d addr=%h exp ov=%b busy=%b src=%0d addr=%h",
                 c, out_valid, req_busy, out_src, out_addr,
                 m_ov, m_busy, m_out.src, m_out.addr);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    test_reset();
    test_rsp_vs_req();
    test_rr_busy();
    test_starvation();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
